// File: rtl/rv_regfile_pkg.sv
// Shared constants for the RV32I register file with scoreboard.
package rv_regfile_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREGS = 2 ** AW;
  localparam int unsigned X0    = 0;

endpackage

// File: rtl/regfile_sb_reg.sv
// Enabled register cell with synchronous active-high clear.
module regfile_sb_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// 2R/1W integer register file with write-through bypass and a pending-write
// scoreboard that stalls issue on RAW and WAW hazards.
module regfile_sb
  import rv_regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            stall,
  output logic [AW:0]     pend_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             byp1, byp2, wr_hits_rd, waw, acc;

  assign regs[X0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    regfile_sb_reg #(
      .Width(XLEN)
    ) u_reg (
      .clk  (clk),
      .reset(reset),
      .en   (wr_en && (wr_addr == AW'(i))),
      .d    (wr_data),
      .q    (regs[i])
    );
  end

  assign byp1       = wr_en && (wr_addr == rs1_addr);
  assign byp2       = wr_en && (wr_addr == rs2_addr);
  assign wr_hits_rd = wr_en && (wr_addr == iss_rd);

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == AW'(X0)) begin
      rs1_data = '0;
    end else if (byp1) begin
      rs1_data = wr_data;
    end
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == AW'(X0)) begin
      rs2_data = '0;
    end else if (byp2) begin
      rs2_data = wr_data;
    end
  end

  // A write-back landing this cycle resolves the hazard it would otherwise raise.
  assign rs1_busy = pend_q[rs1_addr] && !byp1;
  assign rs2_busy = pend_q[rs2_addr] && !byp2;
  assign waw      = pend_q[iss_rd] && !wr_hits_rd;
  assign stall    = iss_en && (rs1_busy || rs2_busy || waw);
  assign acc      = iss_en && !stall && (iss_rd != AW'(X0));

  // Clear first, then set: a newly allocated producer outranks the retiring one.
  always_comb begin
    pend_d = pend_q;
    if (wr_en) begin
      pend_d[wr_addr] = 1'b0;
    end
    if (acc) begin
      pend_d[iss_rd] = 1'b1;
    end
    pend_d[X0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed hazard scenarios, then random
// traffic against an array-based reference model with an up/down counter.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
  logic [31:0] rs1_data, rs2_data, wr_data;
  logic        rs1_busy, rs2_busy, wr_en, iss_en, stall;
  logic [5:0]  pend_cnt;

  int errors = 0;
  int checks = 0;
  bit known  = 1'b0;

  logic [31:0] mreg  [32];
  bit          mpend [32];
  int          mcnt;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk     (clk),
    .reset   (reset),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .stall   (stall),
    .pend_cnt(pend_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return mreg[a];
  endfunction

  function automatic bit m_busy(input logic [4:0] a);
    return mpend[a] && !(wr_en && wr_addr == a);
  endfunction

  function automatic bit m_stall();
    return iss_en && (m_busy(rs1_addr) || m_busy(rs2_addr) || m_busy(iss_rd));
  endfunction

  // Apply inputs mid-cycle and check combinational outputs against the model.
  task automatic drive(input bit rst, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit ie, input logic [4:0] rd, input logic [4:0] a1,
                       input logic [4:0] a2);
    @(negedge clk);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_rd = rd; rs1_addr = a1; rs2_addr = a2;
    #1;
    if (known) begin
      chk("rs1_data", rs1_data, m_read(rs1_addr));
      chk("rs2_data", rs2_data, m_read(rs2_addr));
      chk("rs1_busy", 32'(rs1_busy), 32'(m_busy(rs1_addr)));
      chk("rs2_busy", 32'(rs2_busy), 32'(m_busy(rs2_addr)));
      chk("stall", 32'(stall), 32'(m_stall()));
    end
  endtask

  // Advance one edge, update the model from the architectural rules, check pend_cnt.
  task automatic tick();
    bit acc;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mreg[i] = 32'h0;
        mpend[i] = 1'b0;
      end
      mcnt = 0;
      known = 1'b1;
    end else begin
      acc = iss_en && !m_stall() && iss_rd != 0;
      if (wr_en && wr_addr != 0) mreg[wr_addr] = wr_data;
      if (acc && !mpend[iss_rd]) mcnt++;
      if (wr_en && mpend[wr_addr] && !(acc && iss_rd == wr_addr)) mcnt--;
      if (wr_en) mpend[wr_addr] = 1'b0;
      if (acc) mpend[iss_rd] = 1'b1;
    end
    #1;
    if (known) chk("pend_cnt", 32'(pend_cnt), 32'(mcnt));
  endtask

  task automatic cyc(input bit rst, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input bit ie, input logic [4:0] rd, input logic [4:0] a1,
                     input logic [4:0] a2);
    drive(rst, we, wa, wd, ie, rd, a1, a2);
    tick();
  endtask

  initial begin
    // Reset and x0 behaviour
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    chk("x5_after_reset", rs1_data, 32'h0);
    tick();
    cyc(0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    chk("x0_read", rs1_data, 32'h0);
    tick();
    chk("x0_issue_cnt", 32'(pend_cnt), 32'd0);

    // Write with bypass, then stored read
    drive(0, 1, 3, 32'h12345678, 0, 0, 3, 0);
    chk("bypass_x3", rs1_data, 32'h12345678);
    tick();
    drive(0, 0, 0, 0, 0, 0, 3, 0);
    chk("stored_x3", rs1_data, 32'h12345678);
    tick();

    // RAW stall, then resolution by same-cycle write-back
    cyc(0, 0, 0, 0, 1, 7, 0, 0);
    chk("raw_cnt1", 32'(pend_cnt), 32'd1);
    drive(0, 0, 0, 0, 1, 10, 0, 7);
    chk("raw_busy", 32'(rs2_busy), 32'd1);
    chk("raw_stall", 32'(stall), 32'd1);
    tick();
    chk("raw_nochange", 32'(pend_cnt), 32'd1);
    drive(0, 1, 7, 32'hA5A5A5A5, 1, 10, 0, 7);
    chk("raw_byp_busy", 32'(rs2_busy), 32'd0);
    chk("raw_byp_stall", 32'(stall), 32'd0);
    chk("raw_byp_data", rs2_data, 32'hA5A5A5A5);
    tick();

    // WAW stall and set-wins
    cyc(0, 0, 0, 0, 1, 9, 0, 0);
    drive(0, 0, 0, 0, 1, 9, 0, 0);
    chk("waw_stall", 32'(stall), 32'd1);
    tick();
    cyc(0, 1, 9, 32'h99, 1, 9, 0, 0);
    chk("setwins_cnt", 32'(pend_cnt), 32'd2);
    drive(0, 0, 0, 0, 0, 0, 9, 0);
    chk("setwins_busy", 32'(rs1_busy), 32'd1);
    tick();
    cyc(0, 1, 9, 32'h9, 0, 0, 0, 0);
    cyc(0, 1, 10, 32'hA, 0, 0, 0, 0);

    // Counter full range and redundant write-back
    for (int r = 1; r < 32; r++) cyc(0, 0, 0, 0, 1, 5'(r), 0, 0);
    chk("cnt_full", 32'(pend_cnt), 32'd31);
    for (int r = 1; r < 32; r++) cyc(0, 1, 5'(r), 32'(r * 3), 0, 0, 0, 0);
    chk("cnt_empty", 32'(pend_cnt), 32'd0);
    cyc(0, 1, 1, 32'h1, 0, 0, 0, 0);
    chk("cnt_no_underflow", 32'(pend_cnt), 32'd0);

    // Reset mid-operation
    cyc(0, 1, 4, 32'h11, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4, 0, 0);
    cyc(0, 0, 0, 0, 1, 6, 0, 0);
    cyc(1, 1, 6, 32'h66, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 4, 6);
    chk("rst_x4", rs1_data, 32'h0);
    chk("rst_x6", rs2_data, 32'h0);
    chk("rst_busy", 32'({rs1_busy, rs2_busy}), 32'd0);
    chk("rst_cnt", 32'(pend_cnt), 32'd0);
    tick();

    // Random traffic concentrated on a few registers to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      bit          rst, we, ie;
      logic [4:0]  wa, rd, a1, a2;
      rst = ($urandom_range(0, 199) == 0);
      we  = $urandom_range(0, 1) == 1;
      ie  = $urandom_range(0, 1) == 1;
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a1  = 5'($urandom_range(0, 7));
      a2  = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 7));
      cyc(rst, we, wa, $urandom, ie, rd, a1, a2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
